// File: rtl/line_buffer_n.sv
// line_buffer_n: multi-row line buffer that presents a vertical column of
// ROWS taps per accepted pixel, with self-clearing line memories.
module line_buffer_n #(
    parameter int DATA_W   = 32,
    parameter int LINE_LEN = 76,
    parameter int ROWS     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic                        write_en,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        ready,
    output logic                        rd_valid,
    output logic [ROWS*DATA_W-1:0]      rd_taps,
    output logic [$clog2(LINE_LEN)-1:0] rd_col,
    output logic                        line_end
);

    localparam int CW = $clog2(LINE_LEN);
    localparam int LW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [LW-1:0] LINE_MAX = LW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_FILL,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] clr_q, clr_d;
    logic [LW-1:0] lines_q, lines_d;

    logic                   rd_valid_q;
    logic [ROWS*DATA_W-1:0] rd_taps_q;
    logic [CW-1:0]          rd_col_q;
    logic                   line_end_q;

    logic [DATA_W-1:0] mem_q [ROWS-1][LINE_LEN];

    logic                   accept;
    logic                   restart;
    logic [CW-1:0]          wcol;
    logic [ROWS*DATA_W-1:0] taps_w;

    assign ready    = (state_q == S_FILL) || (state_q == S_RUN);
    assign accept   = write_en && ready;
    assign restart  = frame_start && ready;
    // A pixel arriving with frame_start lands in column 0 of the new frame.
    assign wcol     = restart ? '0 : col_q;

    assign rd_valid = rd_valid_q;
    assign rd_taps  = rd_taps_q;
    assign rd_col   = rd_col_q;
    assign line_end = line_end_q;

    always_comb begin
        taps_w = '0;
        taps_w[DATA_W-1:0] = wr_data;
        for (int k = 1; k < ROWS; k++) begin
            taps_w[k*DATA_W +: DATA_W] = mem_q[k-1][wcol];
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        clr_d   = clr_q;
        lines_d = lines_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == COL_LAST) begin
                    clr_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL, S_RUN: begin
                if (restart) begin
                    col_d   = '0;
                    lines_d = '0;
                    state_d = S_FILL;
                end
                if (accept) begin
                    if (wcol == COL_LAST) begin
                        col_d = '0;
                        if (lines_d != LINE_MAX) begin
                            lines_d = lines_d + 1'b1;
                        end
                    end else begin
                        col_d = wcol + 1'b1;
                    end
                    if (state_d == S_FILL && lines_d == LINE_MAX) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                clr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLEAR;
            col_q   <= '0;
            clr_q   <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            clr_q   <= clr_d;
            lines_q <= lines_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_taps_q  <= '0;
            rd_col_q   <= '0;
            line_end_q <= 1'b0;
        end else begin
            rd_valid_q <= accept && !restart && (state_q == S_RUN);
            if (accept) begin
                rd_taps_q  <= taps_w;
                rd_col_q   <= wcol;
                line_end_q <= (wcol == COL_LAST);
            end
        end
    end

    // Line memories carry no reset; the CLEAR sweep zeroes them instead.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            for (int k = 0; k < ROWS - 1; k++) begin
                mem_q[k][clr_q] <= '0;
            end
        end else if (accept) begin
            mem_q[0][wcol] <= wr_data;
            for (int k = 1; k < ROWS - 1; k++) begin
                mem_q[k][wcol] <= mem_q[k-1][wcol];
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_n.sv
// Bench for line_buffer_n (ROWS=3, LINE_LEN=4, DATA_W=8) using a
// per-column history model and an expected-output queue.
module tb_line_buffer_n;

    localparam int DW = 8;
    localparam int LL = 4;
    localparam int RW = 3;

    typedef struct packed {
        logic          valid;
        logic [23:0]   taps;
        logic [1:0]    col;
        logic          le;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          write_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          ready;
    logic          rd_valid;
    logic [23:0]   rd_taps;
    logic [1:0]    rd_col;
    logic          line_end;

    int total = 0;
    int bad = 0;
    int nvalid = 0;

    logic [7:0] hist [0:LL-1][0:RW-2];
    int col_m;
    int n_m;
    exp_t q[$];
    exp_t last;

    line_buffer_n #(
        .DATA_W(DW),
        .LINE_LEN(LL),
        .ROWS(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .write_en(write_en),
        .wr_data(wr_data),
        .ready(ready),
        .rd_valid(rd_valid),
        .rd_taps(rd_taps),
        .rd_col(rd_col),
        .line_end(line_end)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int c = 0; c < LL; c++)
            for (int k = 0; k < RW - 1; k++)
                hist[c][k] = 8'h00;
        col_m = 0;
        n_m = 0;
        last = '0;
        q.delete();
    endtask

    task automatic step(input logic we, input logic fs, input logic [7:0] d);
        exp_t e;
        int c;
        write_en = we;
        frame_start = fs;
        wr_data = d;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready got=%b want=1", ready);
        end
        if (we) begin
            if (fs) n_m = 0;
            c = fs ? 0 : col_m;
            e.valid = (n_m >= (RW - 1) * LL);
            e.taps = {hist[c][1], hist[c][0], d};
            e.col = 2'(c);
            e.le = (c == LL - 1);
            q.push_back(e);
            hist[c][1] = hist[c][0];
            hist[c][0] = d;
            col_m = (c + 1) % LL;
            n_m++;
        end else if (fs) begin
            col_m = 0;
            n_m = 0;
        end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        frame_start = 1'b0;
        if (we) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue empty");
            end else begin
                e = q.pop_front();
                total += 4;
                if (rd_valid !== e.valid) begin
                    bad++;
                    $display("FAIL valid got=%b want=%b", rd_valid, e.valid);
                end
                if (rd_taps !== e.taps) begin
                    bad++;
                    $display("FAIL taps got=%h want=%h", rd_taps, e.taps);
                end
                if (rd_col !== e.col) begin
                    bad++;
                    $display("FAIL col got=%0d want=%0d", rd_col, e.col);
                end
                if (line_end !== e.le) begin
                    bad++;
                    $display("FAIL line_end got=%b want=%b", line_end, e.le);
                end
                if (rd_valid === 1'b1) nvalid++;
                last = e;
            end
        end else begin
            total += 2;
            if (rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_valid got=%b want=0", rd_valid);
            end
            if (rd_taps !== last.taps) begin
                bad++;
                $display("FAIL hold_taps got=%h want=%h", rd_taps, last.taps);
            end
        end
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == LL - 1) begin
                total++;
                if (ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_early got=%b want=0", tag, ready);
                end
            end
        end
        total++;
        if (n != LL || ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_clear cycles got=%0d want=%0d", tag, n, LL);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_ready got=%b want=0", ready);
        end
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid got=%b want=0", rd_valid);
        end
        if (rd_taps !== 24'h0) begin
            bad++;
            $display("FAIL rst_taps got=%h want=0", rd_taps);
        end
        if (rd_col !== 2'd0) begin
            bad++;
            $display("FAIL rst_col got=%0d want=0", rd_col);
        end
        if (line_end !== 1'b0) begin
            bad++;
            $display("FAIL rst_le got=%b want=0", line_end);
        end
        rst = 1'b0;
        model_clear();
        wait_clear("rst");
    endtask

    task automatic test_fill();
        int v0 = nvalid;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 9) begin
                total++;
                if (rd_taps !== 24'h010509 || rd_col !== 2'd0) begin
                    bad++;
                    $display("FAIL first_out got=%h/%0d want=010509/0",
                             rd_taps, rd_col);
                end
            end
            if (i == 12) begin
                total++;
                if (rd_taps !== 24'h04080C || line_end !== 1'b1) begin
                    bad++;
                    $display("FAIL px12 got=%h/%b want=04080c/1",
                             rd_taps, line_end);
                end
            end
        end
        total++;
        if (nvalid - v0 != 4) begin
            bad++;
            $display("FAIL fill_count got=%0d want=4", nvalid - v0);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 8'd13);
        total++;
        if (rd_taps !== 24'h05090D || rd_col !== 2'd0) begin
            bad++;
            $display("FAIL wrap got=%h/%0d want=05090d/0", rd_taps, rd_col);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'(20 + i));
            step(1'b0, 1'b0, 8'hEE);
        end
    endtask

    task automatic test_frame_start();
        int v0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(40 + i));
        v0 = nvalid;
        step(1'b1, 1'b1, 8'd100);
        total++;
        if (rd_col !== 2'd0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL fs_first got=%0d/%b want=0/0", rd_col, rd_valid);
        end
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 8'(100 + i));
        total++;
        if (nvalid != v0) begin
            bad++;
            $display("FAIL fs_fill got=%0d want=0", nvalid - v0);
        end
        step(1'b1, 1'b0, 8'd108);
        total++;
        if (rd_taps !== 24'h64686C) begin
            bad++;
            $display("FAIL fs_run got=%h want=64686c", rd_taps);
        end
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(150 + i));
    endtask

    task automatic test_mid_reset();
        int v0;
        step(1'b1, 1'b0, 8'd200);
        #2;
        rst = 1'b1;
        #1;
        total += 2;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_ready got=%b want=0", ready);
        end
        if (rd_taps !== 24'h0 || rd_col !== 2'd0) begin
            bad++;
            $display("FAIL mid_out got=%h/%0d want=0/0", rd_taps, rd_col);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        wait_clear("mid");
        v0 = nvalid;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(60 + i));
        total++;
        if (nvalid != v0) begin
            bad++;
            $display("FAIL mid_fill got=%0d want=0", nvalid - v0);
        end
        for (int i = 8; i < 12; i++) step(1'b1, 1'b0, 8'(60 + i));
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_toggle();
        test_frame_start();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_buffer_n.md
# line_buffer_n

Parametrised multi-row line buffer for the edge detector datapath, generalising the fixed 76-deep, 32-bit shift register. It generates its own column addressing, stores ROWS-1 previous image lines, and on every accepted pixel presents a vertical column of ROWS taps (current pixel plus the same column from each earlier line) for the downstream kernel window. It sits between the pixel source and the convolution stage.

## Interface

- DATA_W, 32, pixel word width in bits (>=1)
- LINE_LEN, 76, pixels per line (>=2)
- ROWS, 3, taps presented per output (>=2); ROWS-1 lines stored
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  synchronous restart of column/line counters (memory kept)
- write_en  in  1  pixel offered this cycle
- wr_data  in  DATA_W  pixel value
- ready  out  1  block accepts a pixel this cycle
- rd_valid  out  1  rd_taps holds a complete column (registered)
- rd_taps  out  ROWS*DATA_W  tap k at bits [k*DATA_W +: DATA_W]; tap 0 = newest pixel, tap k = same column k lines earlier
- rd_col  out  clog2(LINE_LEN)  column index of the pixel in rd_taps
- line_end  out  1  rd_taps pixel was column LINE_LEN-1 (qualified by output register update, asserted even during FILL)

## Operation

- Accept = write_en && ready. Nothing changes on cycles without accept except CLEAR progress and frame_start.
- Storage: ROWS-1 line memories of LINE_LEN words. On accept at column c: tap k output = line[k-1][c] (pre-write value), then line[k][c] <= line[k-1][c] for k>=1, line[0][c] <= wr_data.
- Column counter col: 0..LINE_LEN-1, increments per accept, wraps to 0 after LINE_LEN-1.
- Line counter lines: increments on wrap, saturates at ROWS-1.
- States:
  - CLEAR: entered on rst. Writes zero to column clr_idx of every line memory, clr_idx 0..LINE_LEN-1, one column per cycle. ready=0. After column LINE_LEN-1 -> FILL.
  - FILL: ready=1; accepts pixels; rd_valid=0. When lines reaches ROWS-1 (wrap of line ROWS-2) -> RUN.
  - RUN: ready=1; every accept produces rd_valid=1 next cycle.
- frame_start (FILL or RUN): col<=0, lines<=0, state<=FILL. Memory untouched. If write_en is also high, that pixel is accepted as column 0, line 0 of the new frame. frame_start ignored in CLEAR.
- rst mid-operation: counters, outputs and state reset immediately; CLEAR re-runs in full, discarding stored lines.

## Timing

- Reset values: ready=0, rd_valid=0, rd_taps=0, rd_col=0, line_end=0, state=CLEAR, col=0, lines=0.
- ready rises on the clock edge ending the LINE_LEN-th CLEAR cycle: exactly LINE_LEN cycles low after rst release.
- Latency: accept on edge N -> rd_taps/rd_col/line_end/rd_valid valid after edge N, held until next accept.
- rd_valid is high for exactly one cycle per accept in RUN; low on non-accept cycles.
- Full-rate: one accept per cycle sustained indefinitely; no back-pressure outside CLEAR.
- First valid output: accept of pixel index (ROWS-1)*LINE_LEN (0-based) after CLEAR or frame_start.
- Widths: col/rd_col are clog2(LINE_LEN) bits; lines is clog2(ROWS) bits; no arithmetic on data.

## Test plan

- ROWS=3, LINE_LEN=4, DATA_W=8: assert rst, release -> ready=0 for exactly 4 cycles, all outputs 0, then ready=1.
- Same config, write 1..12 back-to-back -> rd_valid first high after pixel 9 with taps {9,5,1}, rd_col=0; pixel 12 gives {12,8,4}, rd_col=3, line_end=1; 4 valids total.
- Continue with pixel 13 -> taps {13,9,5}, rd_col=0 (column wrap, lines saturated).
- Toggle write_en 1/0 during RUN -> rd_valid pulses only after accepts; rd_taps holds between.
- frame_start with write_en, pixel 100, after 6 pixels -> rd_col=0, rd_valid=0 for next 8 accepts, then taps show new-frame data; old memory contents appear in tap 2 only as intended by shift.
- rst asserted mid-line in RUN -> ready drops immediately, 4 CLEAR cycles, then taps of first RUN output show zeros from cleared lines only if frame is short (write 8 pixels after reset: no rd_valid).
